// File: rtl/iq_stream_bist.sv
// iq_stream_bist
//
// On-board stimulus/checker harness for the IQ classification networks.
// It streams a stored IQ frame from an input ROM into the network. Each beat
// carries LANES samples, beats can be separated by a programmable idle gap,
// and the frame can be repeated several times per run. Every network output
// vector is compared against an expected ROM. The harness counts passes and
// failures, records the first failing output index, and flags timeout and
// overrun conditions.
//
// Ports
//   clk         clock; all logic runs on the rising edge
//   rst         synchronous reset, active low
//   start       run request; honoured only in IDLE or DONE
//   in_addr     input ROM beat address (ROM has 1-cycle read latency)
//   in_rdata    input ROM data
//   vld_in      beat valid to the network
//   data_in     beat to the network (in_rdata passed straight through)
//   vld_out     network output valid
//   data_out    network output vector
//   exp_addr    expected ROM address (ROM has 1-cycle read latency)
//   exp_rdata   expected ROM data
//   busy        high while streaming or draining
//   done        high once a run has finished
//   timeout     sticky; the run ended because outputs stopped arriving
//   overrun     sticky; an output arrived when none was expected
//   pass_cnt    matching outputs, saturating at 0xFFFF
//   fail_cnt    mismatching outputs, saturating at 0xFFFF
//   first_fail  index of the first mismatching output, 0xFFFF if none
module iq_stream_bist #(
  parameter int BW_IN       = 16,
  parameter int LANES       = 2,
  parameter int SIG_LEN_IN  = 1024,
  parameter int CH_OUT      = 24,
  parameter int BW_OUT      = 16,
  parameter int SIG_LEN_OUT = 1,
  parameter int N_FRAMES    = 2,
  parameter int GAP         = 0,
  parameter int TIMEOUT     = 4096,
  localparam int BEATS      = SIG_LEN_IN / LANES,
  localparam int AW_IN      = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int AW_OUT     = (SIG_LEN_OUT > 1) ? $clog2(SIG_LEN_OUT) : 1,
  localparam int DW_IN      = LANES * 2 * BW_IN,
  localparam int DW_OUT     = CH_OUT * BW_OUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [AW_IN-1:0]  in_addr,
  input  logic [DW_IN-1:0]  in_rdata,
  output logic              vld_in,
  output logic [DW_IN-1:0]  data_in,
  input  logic              vld_out,
  input  logic [DW_OUT-1:0] data_out,
  output logic [AW_OUT-1:0] exp_addr,
  input  logic [DW_OUT-1:0] exp_rdata,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              overrun,
  output logic [15:0]       pass_cnt,
  output logic [15:0]       fail_cnt,
  output logic [15:0]       first_fail
);

  localparam int TOTAL_BEATS = N_FRAMES * BEATS;
  localparam int TOTAL_OUT   = N_FRAMES * SIG_LEN_OUT;
  localparam int BCW         = $clog2(TOTAL_BEATS + 1);
  localparam int OCW         = $clog2(TOTAL_OUT + 1);
  localparam int GCW         = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam int TCW         = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state;
  logic              issue;
  logic [BCW-1:0]    beat_cnt;
  logic [GCW-1:0]    gap_cnt;
  logic [OCW-1:0]    out_idx;
  logic              cmp_pend;
  logic [OCW-1:0]    cmp_idx;
  logic [DW_OUT-1:0] out_latch;
  logic [TCW-1:0]    to_cnt;
  logic              accept;
  logic              all_cmp;

  // The network sees the ROM word unchanged; the ROM latency is absorbed by
  // delaying the issue flag by one cycle to form vld_in.
  assign data_in = in_rdata;

  // Outputs are accepted only while a run is active and before every
  // expected vector has been claimed.
  assign accept  = ((state == S_RUN) || (state == S_DRAIN)) &&
                   (out_idx != OCW'(TOTAL_OUT));

  // All outputs are compared once every vector has been accepted and the
  // last compare has retired.
  assign all_cmp = (out_idx == OCW'(TOTAL_OUT)) && !cmp_pend;

  // Single state machine with registered outputs. The run is a pipeline:
  // the accept stage latches an output and presents its expected ROM
  // address, and the compare stage checks that output one cycle later.
  // The state case comes last so that its start-of-run clears win over
  // stage updates in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      issue      <= 1'b0;
      vld_in     <= 1'b0;
      in_addr    <= '0;
      beat_cnt   <= '0;
      gap_cnt    <= '0;
      out_idx    <= '0;
      exp_addr   <= '0;
      cmp_pend   <= 1'b0;
      cmp_idx    <= '0;
      out_latch  <= '0;
      to_cnt     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      overrun    <= 1'b0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      first_fail <= 16'hFFFF;
    end else begin
      vld_in <= issue;

      // Compare stage: exp_rdata now holds the word addressed in the
      // accept cycle.
      if (cmp_pend) begin
        cmp_pend <= 1'b0;
        if (out_latch == exp_rdata) begin
          if (pass_cnt != 16'hFFFF) pass_cnt <= pass_cnt + 16'd1;
        end else begin
          if (fail_cnt != 16'hFFFF) fail_cnt <= fail_cnt + 16'd1;
          if (first_fail == 16'hFFFF) first_fail <= 16'(cmp_idx);
        end
      end

      // Accept stage: exp_addr already points at this output's expected
      // vector, so the ROM reads it on this edge.
      if (vld_out) begin
        if (accept) begin
          out_latch <= data_out;
          cmp_idx   <= out_idx;
          cmp_pend  <= 1'b1;
          out_idx   <= out_idx + OCW'(1);
          exp_addr  <= (exp_addr == AW_OUT'(SIG_LEN_OUT - 1)) ? '0 :
                       exp_addr + AW_OUT'(1);
        end else begin
          overrun <= 1'b1;
        end
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_RUN;
            busy       <= 1'b1;
            done       <= 1'b0;
            issue      <= 1'b1;
            in_addr    <= '0;
            beat_cnt   <= '0;
            gap_cnt    <= '0;
            out_idx    <= '0;
            exp_addr   <= '0;
            cmp_pend   <= 1'b0;
            to_cnt     <= '0;
            timeout    <= 1'b0;
            overrun    <= 1'b0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            first_fail <= 16'hFFFF;
          end
        end

        // in_addr is held across the idle gap and advances only when the
        // next beat is issued, so it always names the beat in flight.
        S_RUN: begin
          if (issue) begin
            if (beat_cnt == BCW'(TOTAL_BEATS - 1)) begin
              issue <= 1'b0;
              state <= S_DRAIN;
            end else if (GAP == 0) begin
              beat_cnt <= beat_cnt + BCW'(1);
              in_addr  <= (in_addr == AW_IN'(BEATS - 1)) ? '0 :
                          in_addr + AW_IN'(1);
            end else begin
              issue   <= 1'b0;
              gap_cnt <= GCW'(GAP);
            end
          end else if (gap_cnt == GCW'(1)) begin
            issue    <= 1'b1;
            beat_cnt <= beat_cnt + BCW'(1);
            in_addr  <= (in_addr == AW_IN'(BEATS - 1)) ? '0 :
                        in_addr + AW_IN'(1);
          end else begin
            gap_cnt <= gap_cnt - GCW'(1);
          end
        end

        // The timeout counter measures consecutive silent cycles. An output
        // arriving in the final cycle is still accepted, and its compare
        // retires in DONE.
        S_DRAIN: begin
          if (all_cmp) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (to_cnt == TCW'(TIMEOUT)) begin
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else if (vld_out) begin
            to_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + TCW'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
